// File: rtl/booth_pp_accumulator_if.sv
// Operand/result handshake bundle for booth_pp_accumulator.
// The addend field exists only when FMAC_ADDEND_EN is defined.
interface booth_pp_accumulator_if;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  pp0;
    logic [8:0]  pp1;
    logic [8:0]  pp2;
    logic [8:0]  pp3;
`ifdef FMAC_ADDEND_EN
    logic [15:0] addend;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

`ifdef FMAC_ADDEND_EN
    modport master (output in_valid, pp0, pp1, pp2, pp3, addend, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  in_valid, pp0, pp1, pp2, pp3, addend, out_ready,
                    output in_ready, out_valid, result, busy);
`else
    modport master (output in_valid, pp0, pp1, pp2, pp3, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  in_valid, pp0, pp1, pp2, pp3, out_ready,
                    output in_ready, out_valid, result, busy);
`endif
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sequential sum of four radix-4 Booth partial products (weight 4^i), one per cycle.
// Define FMAC_ADDEND_EN to seed the accumulator with a signed addend (fused multiply-add).
module booth_pp_accumulator (
    input  logic                   clk,
    input  logic                   rst,
    booth_pp_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [15:0] acc_q, acc_d;
    logic [8:0]  pp_q  [4];
    logic [8:0]  pp_d  [4];
    logic [8:0]  pp_in [4];
    logic [15:0] term  [4];
    logic        accept;

    assign pp_in[0] = bus.pp0;
    assign pp_in[1] = bus.pp1;
    assign pp_in[2] = bus.pp2;
    assign pp_in[3] = bus.pp3;

    // Bit 8 is the sign; extend to 16 bits, then apply the 4^i weight.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_term
            assign term[gi] = {{7{pp_q[gi][8]}}, pp_q[gi]} << (2 * gi);
        end
    endgenerate

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == ACCUM);
    assign bus.result    = acc_q;
    assign accept        = bus.in_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        pp_d    = pp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pp_d  = pp_in;
`ifdef FMAC_ADDEND_EN
                    acc_d = bus.addend;
`else
                    acc_d = 16'h0000;
`endif
                    k_d     = 2'd0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + term[k_q];
                k_d   = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            acc_q   <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                pp_q[i] <= 9'h000;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            pp_q    <= pp_d;
        end
    end
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench for booth_pp_accumulator: driver pushes expected results, monitor pops at handshake.
// Works in both builds (FMAC_ADDEND_EN defined or not).
module tb_booth_pp_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_pp_accumulator_if bus();

    booth_pp_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [15:0] res;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int          ready_mode = 2;   // 0 random, 1 hold low, 2 always high

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain signed arithmetic on the weighted partial products.
    function automatic logic [15:0] model(input logic [8:0] p [4], input logic [15:0] ad);
        int s;
`ifdef FMAC_ADDEND_EN
        s = int'($signed(ad));
`else
        s = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            s = s + int'($signed(p[i])) * (1 << (2 * i));
        end
        return s[15:0];
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'($urandom_range(0, 1));
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor
    logic        prev_valid = 1'b0;
    logic        prev_hold  = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [15:0] prev_res   = 16'h0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) begin
                tests++;
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL post_handshake_idle: out_valid=%b in_ready=%b, required 0/1",
                             bus.out_valid, bus.in_ready);
                end
            end
            if (prev_hold) begin
                tests++;
                if (bus.out_valid !== 1'b1 || bus.result !== prev_res) begin
                    fails++;
                    $display("FAIL hold_stable: out_valid=%b result=%h, required 1/%h",
                             bus.out_valid, bus.result, prev_res);
                end
            end
            if (bus.out_valid === 1'b1) begin
                tests++;
                if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
                    fails++;
                    $display("FAIL done_flags: in_ready=%b busy=%b, required 0/0",
                             bus.in_ready, bus.busy);
                end
                if (!prev_valid) begin
                    tests++;
                    if (sbq.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_valid: out_valid=1 with empty scoreboard, required 0");
                    end else if (cyc != sbq[0].acc_cyc + 4) begin
                        fails++;
                        $display("FAIL latency: valid %0d edges after accept, required 4",
                                 cyc - sbq[0].acc_cyc);
                    end
                end
                if (bus.out_ready === 1'b1 && sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    tests++;
                    if (bus.result !== e.res) begin
                        fails++;
                        $display("FAIL result: got %h, required %h", bus.result, e.res);
                    end else begin
                        $display("[TB] result %h ok at cycle %0d", bus.result, cyc);
                    end
                end
            end
            prev_valid = (bus.out_valid === 1'b1);
            prev_hold  = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_hs    = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
            prev_res   = bus.result;
        end
    end

    task automatic send(input logic [8:0] p0, input logic [8:0] p1, input logic [8:0] p2,
                        input logic [8:0] p3, input logic [15:0] ad,
                        input logic use_exp, input logic [15:0] exp_res);
        int   n;
        exp_t e;
        logic [8:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        bus.pp0 = p0; bus.pp1 = p1; bus.pp2 = p2; bus.pp3 = p3;
`ifdef FMAC_ADDEND_EN
        bus.addend = ad;
`endif
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready=%b after 100 cycles, required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.res     = use_exp ? exp_res : model(p, ad);
        e.acc_cyc = cyc;
        sbq.push_back(e);
        bus.in_valid = 1'b0;
        $display("[TB] accept pp=%h,%h,%h,%h ad=%h exp=%h", p0, p1, p2, p3, ad, e.res);
        // Scramble operands: the block must ignore them once captured.
        bus.pp0 = 9'($urandom); bus.pp1 = 9'($urandom);
        bus.pp2 = 9'($urandom); bus.pp3 = 9'($urandom);
`ifdef FMAC_ADDEND_EN
        bus.addend = 16'($urandom);
`endif
        tests++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL accept_busy: busy=%b in_ready=%b, required 1/0", bus.busy, bus.in_ready);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        logic [15:0] basic_exp;
        int n;
`ifdef FMAC_ADDEND_EN
        basic_exp = 16'h0019;
`else
        basic_exp = 16'h0009;
`endif
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.pp0 = 9'h0; bus.pp1 = 9'h0; bus.pp2 = 9'h0; bus.pp3 = 9'h0;
`ifdef FMAC_ADDEND_EN
        bus.addend = 16'h0;
`endif
        #3;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, required 1/0/0/0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 2;

        // Directed cases; the first accepts on the first edge after reset release.
        send(9'h001, 9'h002, 9'h000, 9'h000, 16'h0010, 1'b1, basic_exp);
        send(9'h000, 9'h000, 9'h000, 9'h1FF, 16'h0000, 1'b1, 16'hFFC0);
        send(9'h080, 9'h000, 9'h000, 9'h100, 16'h0000, 1'b1, 16'hC080);
`ifdef FMAC_ADDEND_EN
        send(9'h000, 9'h000, 9'h000, 9'h0FF, 16'h7FFF, 1'b1, 16'hBFBF);
`endif
        drain();

        // Backpressure: hold out_ready low for 10 cycles in DONE.
        @(negedge clk);
        ready_mode = 1;
        send(9'h001, 9'h002, 9'h000, 9'h000, 16'h0010, 1'b1, basic_exp);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_valid: out_valid=%b, required 1", bus.out_valid);
        end
        repeat (10) @(negedge clk);
        ready_mode = 2;
        drain();

        // Reset at k=2 discards the operation.
        @(negedge clk);
        ready_mode = 0;
        send(9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 16'($urandom), 1'b0, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.result !== 16'h0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_midop: out_valid=%b result=%h in_ready=%b busy=%b, required 0/0000/1/0",
                     bus.out_valid, bus.result, bus.in_ready, bus.busy);
        end
        sbq.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        send(9'h001, 9'h002, 9'h000, 9'h000, 16'h0010, 1'b1, basic_exp);
        drain();

        // Random back-to-back traffic with random out_ready.
        repeat (40) begin
            send(9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 16'($urandom), 1'b0, 16'h0);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog");
    end
endmodule
